// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: valid/ready pipeline register with flush and optional two-entry skid buffer
module pipe_stage_elastic #(
  parameter int DATA_W = 101,
  parameter int CTRL_W = 3,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);
  logic              m_valid, s_valid;
  logic [DATA_W-1:0] m_data, s_data;
  logic [CTRL_W-1:0] m_ctrl, s_ctrl;
  logic              it, m_free;
  // Without skid, in_ready is combinational so the skid entry can never be loaded
  always_comb begin
    in_ready  = (SKID != 0) ? ~s_valid : (out_ready | ~m_valid);
    it        = in_valid & in_ready;
    m_free    = ~m_valid | out_ready;
    out_valid = m_valid;
    out_data  = m_data;
    out_ctrl  = m_valid ? m_ctrl : '0;
    occupancy = {1'b0, m_valid} + {1'b0, s_valid};
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_ctrl  <= '0;
      s_valid <= 1'b0;
      s_data  <= '0;
      s_ctrl  <= '0;
    end else if (m_free) begin
      m_valid <= s_valid | it;
      m_data  <= s_valid ? s_data : it ? in_data : m_data;
      m_ctrl  <= s_valid ? s_ctrl : it ? in_ctrl : '0;
      s_valid <= 1'b0;
    end else if (it) begin
      s_valid <= 1'b1;
      s_data  <= in_data;
      s_ctrl  <= in_ctrl;
    end
  end
endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb_pipe_stage_elastic: checks skid and pass-through stages against a FIFO reference model
module tb_pipe_stage_elastic;
  localparam int DW = 101;
  localparam int CW = 3;
  typedef struct packed {logic [CW-1:0] c; logic [DW-1:0] d;} bund_t;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic rdy1, ov1, rdy0, ov0;
  logic [DW-1:0] od1, od0;
  logic [CW-1:0] oc1, oc0;
  logic [1:0] occ1, occ0;
  bund_t q1[$], q0[$];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) u1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy1),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(ov1), .out_ready(out_ready),
    .out_data(od1), .out_ctrl(oc1), .occupancy(occ1));
  pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) u0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy0),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(ov0), .out_ready(out_ready),
    .out_data(od0), .out_ctrl(oc0), .occupancy(occ0));
  // The stage behaves as a FIFO of capacity 2 (skid) or 1 (pass-through)
  function automatic logic [107:0] exp_vec(int m);
    int n;
    bund_t f;
    logic r;
    n = (m != 0) ? q1.size() : q0.size();
    f = (n == 0) ? '0 : (m != 0) ? q1[0] : q0[0];
    r = (m != 0) ? (n < 2) : (out_ready || n == 0);
    return {r, n > 0, f.c, f.d, 2'(n)};
  endfunction
  function automatic logic [107:0] dut_vec(int m);
    logic v;
    v = ((m != 0) ? q1.size() : q0.size()) > 0;
    return (m != 0) ? {rdy1, ov1, oc1, v ? od1 : '0, occ1} : {rdy0, ov0, oc0, v ? od0 : '0, occ0};
  endfunction
  task automatic cycle();
    logic it0, it1, ot0, ot1;
    bund_t b;
    b = {in_ctrl, in_data};
    it1 = in_valid && q1.size() < 2;
    ot1 = out_ready && q1.size() > 0;
    it0 = in_valid && (out_ready || q0.size() == 0);
    ot0 = out_ready && q0.size() > 0;
    @(posedge clk);
    if (rst || flush) begin
      q0.delete();
      q1.delete();
    end else begin
      if (ot1) void'(q1.pop_front());
      if (it1) q1.push_back(b);
      if (ot0) void'(q0.pop_front());
      if (it0) q0.push_back(b);
    end
    #1;
  endtask
  task automatic do_reset();
    rst = 1; flush = 0; in_valid = 0; out_ready = 0;
    cycle();
    cycle();
    rst = 0;
  endtask
  task automatic push(input logic [DW-1:0] d, input logic [CW-1:0] c);
    in_valid = 1; in_data = d; in_ctrl = c;
    cycle();
    in_valid = 0;
  endtask
  task automatic test_reset();
    do_reset();
    #1;
    for (int m = 0; m < 2; m++) begin
      total++;
      if (dut_vec(m) !== exp_vec(m)) begin bad++; $display("FAIL reset m%0d got=%h exp=%h", m, dut_vec(m), exp_vec(m)); end
    end
    total++;
    if ({rdy1, ov1, oc1, od1, occ1} !== {1'b1, 1'b0, 3'b0, {DW{1'b0}}, 2'b0}) begin
      bad++; $display("FAIL reset_zero got=%b/%b/%h/%h/%0d exp=1/0/0/0/0", rdy1, ov1, oc1, od1, occ1);
    end
  endtask
  task automatic test_stream();
    do_reset();
    out_ready = 1; in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      in_data = DW'(16 + i); in_ctrl = 3'd1;
      if (i == 3) in_valid = 0;
      #1;
      for (int m = 0; m < 2; m++) begin
        total++;
        if (dut_vec(m) !== exp_vec(m)) begin bad++; $display("FAIL stream m%0d got=%h exp=%h", m, dut_vec(m), exp_vec(m)); end
      end
      if (i > 0) begin
        total++;
        if (ov1 !== 1'b1 || od1 !== DW'(15 + i) || occ1 !== 2'd1 || rdy1 !== 1'b1) begin
          bad++; $display("FAIL stream_data got=%b/%h/%0d exp=1/%h/1", ov1, od1, occ1, DW'(15 + i));
        end
      end
      if (i < 3) cycle();
    end
  endtask
  task automatic test_stall();
    do_reset();
    push(DW'('hA), 3'd2);
    push(DW'('hB), 3'd4);
    in_valid = 1; in_data = DW'('hC); in_ctrl = 3'd7;
    cycle();
    in_valid = 0;
    #1;
    total++;
    if (od1 !== DW'('hA) || occ1 !== 2'd2 || rdy1 !== 1'b0 || oc1 !== 3'd2) begin
      bad++; $display("FAIL stall_hold got=%h/%0d/%b exp=a/2/0", od1, occ1, rdy1);
    end
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      for (int m = 0; m < 2; m++) begin
        total++;
        if (dut_vec(m) !== exp_vec(m)) begin bad++; $display("FAIL stall_drain m%0d got=%h exp=%h", m, dut_vec(m), exp_vec(m)); end
      end
      if (i == 1) begin
        total++;
        if (od1 !== DW'('hB) || ov1 !== 1'b1) begin bad++; $display("FAIL stall_order got=%h exp=b", od1); end
      end
      cycle();
    end
    total++;
    if (rdy1 !== 1'b1 || occ1 !== 2'd0 || ov1 !== 1'b0) begin
      bad++; $display("FAIL stall_empty got=%b/%0d/%b exp=1/0/0", rdy1, occ1, ov1);
    end
  endtask
  task automatic test_flush();
    do_reset();
    push(DW'('h55), 3'b011);
    push(DW'('h56), 3'b001);
    flush = 1; in_valid = 1; in_data = DW'('h66); in_ctrl = 3'd5;
    cycle();
    #1;
    total++;
    if (rdy1 !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b exp=1", rdy1); end
    cycle();
    flush = 0; in_valid = 0; out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      for (int m = 0; m < 2; m++) begin
        total++;
        if (dut_vec(m) !== exp_vec(m)) begin bad++; $display("FAIL flush m%0d got=%h exp=%h", m, dut_vec(m), exp_vec(m)); end
      end
      total++;
      if (ov1 !== 1'b0 || oc1 !== 3'd0 || occ1 !== 2'd0) begin
        bad++; $display("FAIL flush_bubble got=%b/%h/%0d exp=0/0/0", ov1, oc1, occ1);
      end
      cycle();
    end
  endtask
  task automatic test_simultaneous();
    for (int k = 0; k < 2; k++) begin
      do_reset();
      push(DW'('h31), 3'd1);
      push(DW'('h32), 3'd2);
      rst = 1; flush = (k == 0); in_valid = 1; in_data = DW'('h99);
      cycle();
      rst = 0; flush = 0; in_valid = 0;
      #1;
      total++;
      if ({rdy1, ov1, oc1, od1, occ1} !== {1'b1, 1'b0, 3'b0, {DW{1'b0}}, 2'b0}) begin
        bad++; $display("FAIL simul_clear k%0d got=%b/%b/%h/%h/%0d exp=1/0/0/0/0", k, rdy1, ov1, oc1, od1, occ1);
      end
      out_ready = 1;
      push(DW'('h77), 3'd3);
      #1;
      total++;
      if (ov1 !== 1'b1 || od1 !== DW'('h77) || oc1 !== 3'd3) begin
        bad++; $display("FAIL simul_next k%0d got=%b/%h exp=1/77", k, ov1, od1);
      end
    end
  endtask
  task automatic test_pass_through();
    logic [2:0] pat;
    pat = 3'b101;
    do_reset();
    in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      out_ready = pat[i]; in_data = DW'('h40 + i); in_ctrl = 3'd6;
      #1;
      total++;
      if (dut_vec(0) !== exp_vec(0) || rdy0 !== (out_ready | ~ov0) || occ0 > 2'd1) begin
        bad++; $display("FAIL pass_through got=%h exp=%h", dut_vec(0), exp_vec(0));
      end
      cycle();
    end
    in_valid = 0;
  endtask
  task automatic test_random();
    logic [127:0] r;
    for (int mode = 0; mode < 2; mode++) begin
      do_reset();
      for (int i = 0; i < 500; i++) begin
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        in_valid = ($urandom_range(0, 3) != 0);
        out_ready = (mode == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) != 0);
        in_data = r[DW-1:0];
        in_ctrl = CW'($urandom_range(1, 7));
        #1;
        for (int m = 0; m < 2; m++) begin
          total++;
          if (dut_vec(m) !== exp_vec(m)) begin bad++; $display("FAIL random m%0d i%0d got=%h exp=%h", m, i, dut_vec(m), exp_vec(m)); end
        end
        total++;
        if ((!ov1 && oc1 !== 3'd0) || (!ov0 && oc0 !== 3'd0)) begin
          bad++; $display("FAIL random_bubble i%0d got=%h/%h exp=0", i, oc1, oc0);
        end
        cycle();
      end
    end
  endtask
  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_simultaneous();
    test_pass_through();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
